// File: rtl/mpe_pkg.sv
// Shared constants and types for the mPE feeder slice.
package mpe_pkg;
  localparam int WORD_SZ = 64;
  localparam int ATTR_SZ = 8;
  localparam int MPE_LAT = 3;
  // x^32+x^22+x^2+x+1 as right-shifting Galois feedback taps
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STREAM, S_DRAIN, S_FIN} state_t;
endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR: shifts right one step per enabled cycle, reloads SEED on reset.
module lfsr32 #(
  parameter logic [31:0] SEED = 32'hACE1_2468,
  parameter logic [31:0] POLY = mpe_pkg::LFSR_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] state
);
  logic [31:0] r_state;

  always_ff @(posedge clk) begin
    if (rst)     r_state <= SEED;
    else if (en) r_state <= (r_state >> 1) ^ (r_state[0] ? POLY : '0);
  end

  assign state = r_state;
endmodule

// File: rtl/mpe_feeder.sv
// Drives one mPE per job: setup word, parent gene pairs, random pack, and
// writes each child gene back once the fixed mPE latency has elapsed.
module mpe_feeder #(
  parameter int          WORD_SZ   = mpe_pkg::WORD_SZ,
  parameter int          ADDR_W    = 10,
  parameter int          CNT_W     = 16,
  parameter int          MPE_LAT   = mpe_pkg::MPE_LAT,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WORD_SZ-1:0]          cfg_word,
  input  logic [mpe_pkg::ATTR_SZ-1:0] cfg_genome_id,
  input  logic [CNT_W-1:0]            num_genes,
  output logic                        par_rd_en,
  output logic [ADDR_W-1:0]           par_rd_addr,
  input  logic [WORD_SZ-1:0]          par1_rd_data,
  input  logic [WORD_SZ-1:0]          par2_rd_data,
  output logic                        mpe_setup,
  output logic [WORD_SZ-1:0]          mpe_data_in1,
  output logic [WORD_SZ-1:0]          mpe_data_in2,
  output logic [WORD_SZ-1:0]          mpe_random,
  input  logic [WORD_SZ-1:0]          mpe_child_gene,
  output logic                        child_wr_en,
  output logic [ADDR_W-1:0]           child_wr_addr,
  output logic [WORD_SZ-1:0]          child_wr_data,
  output logic                        busy,
  output logic                        done
);
  import mpe_pkg::*;

  localparam int PIPE_D = MPE_LAT + 2;

  state_t                          r_state, w_state_nxt;
  logic                            w_accept, w_rd_issue, w_enter_fin;
  logic [WORD_SZ-1:0]              r_cfg_word;
  logic [ATTR_SZ-1:0]              r_cfg_id;
  logic [CNT_W-1:0]                r_num, r_rd_cnt;
  logic                            r_busy, r_done;
  logic                            r_par_rd_en;
  logic [ADDR_W-1:0]               r_par_rd_addr;
  logic                            r_setup;
  logic [WORD_SZ-1:0]              r_d1, r_d2;
  logic [PIPE_D-1:0]               r_vld;
  logic [PIPE_D-1:0][ADDR_W-1:0]   r_idx;
  logic                            r_wr_en;
  logic [ADDR_W-1:0]               r_wr_addr;
  logic [WORD_SZ-1:0]              r_wr_data;
  logic [31:0]                     w_lfsr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // r_rd_cnt already counts the read being presented, so STREAM stops once it equals r_num.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rd_issue  = 1'b0;
    w_enter_fin = 1'b0;
    case (r_state)
      S_IDLE:   if (start) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_SETUP;
                end
      S_SETUP:  if (r_num != '0) begin
                  w_rd_issue  = 1'b1;
                  w_state_nxt = S_STREAM;
                end else begin
                  w_state_nxt = S_DRAIN;
                end
      S_STREAM: if (r_rd_cnt != r_num) w_rd_issue  = 1'b1;
                else                   w_state_nxt = S_DRAIN;
      S_DRAIN:  if (r_vld == '0) begin
                  w_enter_fin = 1'b1;
                  w_state_nxt = S_FIN;
                end
      S_FIN:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_word    <= '0;
      r_cfg_id      <= '0;
      r_num         <= '0;
      r_rd_cnt      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_par_rd_en   <= 1'b0;
      r_par_rd_addr <= '0;
      r_setup       <= 1'b0;
      r_d1          <= '0;
      r_d2          <= '0;
      r_vld         <= '0;
      r_idx         <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
    end else begin
      if (w_accept) begin
        r_cfg_word <= cfg_word;
        r_cfg_id   <= cfg_genome_id;
        r_num      <= num_genes;
        r_rd_cnt   <= '0;
        r_busy     <= 1'b1;
      end else if (w_rd_issue) begin
        r_rd_cnt   <= r_rd_cnt + 1'b1;
      end
      if (w_enter_fin) r_busy <= 1'b0;
      r_done        <= w_enter_fin;
      r_par_rd_en   <= w_rd_issue;
      r_par_rd_addr <= w_rd_issue ? r_rd_cnt[ADDR_W-1:0] : '0;

      // r_vld[0] marks parent data arriving this cycle from last cycle's read.
      if (r_state == S_SETUP) begin
        r_setup <= 1'b1;
        r_d1    <= r_cfg_word;
        r_d2    <= {{(WORD_SZ-ATTR_SZ){1'b0}}, r_cfg_id};
      end else if (r_vld[0]) begin
        r_setup <= 1'b0;
        r_d1    <= par1_rd_data;
        r_d2    <= par2_rd_data;
      end else begin
        r_setup <= 1'b0;
        r_d1    <= '0;
        r_d2    <= '0;
      end

      r_vld     <= {r_vld[PIPE_D-2:0], r_par_rd_en};
      r_idx     <= {r_idx[PIPE_D-2:0], r_par_rd_addr};
      r_wr_en   <= r_vld[PIPE_D-1];
      r_wr_addr <= r_vld[PIPE_D-1] ? r_idx[PIPE_D-1] : '0;
      r_wr_data <= r_vld[PIPE_D-1] ? mpe_child_gene  : '0;
    end
  end

  lfsr32 #(.SEED(LFSR_SEED), .POLY(LFSR_POLY)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (r_busy),
    .state (w_lfsr)
  );

  assign par_rd_en     = r_par_rd_en;
  assign par_rd_addr   = r_par_rd_addr;
  assign mpe_setup     = r_setup;
  assign mpe_data_in1  = r_d1;
  assign mpe_data_in2  = r_d2;
  assign mpe_random    = {{(WORD_SZ-32){1'b0}}, w_lfsr};
  assign child_wr_en   = r_wr_en;
  assign child_wr_addr = r_wr_addr;
  assign child_wr_data = r_wr_data;
  assign busy          = r_busy;
  assign done          = r_done;
endmodule

// File: tb/tb_mpe_feeder.sv
// Directed bench for mpe_feeder: job-timeline model checked every cycle, plus literal pins.
module tb_mpe_feeder;
  localparam int WS  = 64;
  localparam int AW  = 10;
  localparam int CW  = 16;
  localparam int LAT = 3;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [WS-1:0] cfg_word;
  logic [7:0]    cfg_genome_id;
  logic [CW-1:0] num_genes;
  logic          par_rd_en;
  logic [AW-1:0] par_rd_addr;
  logic [WS-1:0] par1_rd_data, par2_rd_data;
  logic          mpe_setup;
  logic [WS-1:0] mpe_data_in1, mpe_data_in2, mpe_random, mpe_child_gene;
  logic          child_wr_en;
  logic [AW-1:0] child_wr_addr;
  logic [WS-1:0] child_wr_data;
  logic          busy, done;

  mpe_feeder #(.WORD_SZ(WS), .ADDR_W(AW), .CNT_W(CW), .MPE_LAT(LAT), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_word(cfg_word), .cfg_genome_id(cfg_genome_id),
    .num_genes(num_genes), .par_rd_en(par_rd_en), .par_rd_addr(par_rd_addr),
    .par1_rd_data(par1_rd_data), .par2_rd_data(par2_rd_data), .mpe_setup(mpe_setup),
    .mpe_data_in1(mpe_data_in1), .mpe_data_in2(mpe_data_in2), .mpe_random(mpe_random),
    .mpe_child_gene(mpe_child_gene), .child_wr_en(child_wr_en), .child_wr_addr(child_wr_addr),
    .child_wr_data(child_wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic rst_q  = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Parent gene contents and the mPE transfer function used by the models.
  function automatic logic [63:0] p1(input logic [AW-1:0] a);
    logic [31:0] x = {22'b0, a};
    return {32'h1111_0000 + x, x * 32'd3 + 32'd5};
  endfunction
  function automatic logic [63:0] p2(input logic [AW-1:0] a);
    logic [31:0] x = {22'b0, a};
    return {x * 32'd7, 32'hC0DE_0000 ^ x};
  endfunction
  function automatic logic [63:0] mpe_f(input logic [63:0] d1, input logic [63:0] d2);
    return (d1 ^ {d2[31:0], d2[63:32]}) + 64'd1;
  endfunction
  function automatic logic [31:0] lstep(input logic [31:0] s);
    logic [31:0] taps = '0;
    taps[31] = 1'b1; taps[21] = 1'b1; taps[1] = 1'b1; taps[0] = 1'b1;
    return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

  always @(posedge clk)
    if (par_rd_en) begin
      par1_rd_data <= p1(par_rd_addr);
      par2_rd_data <= p2(par_rd_addr);
    end

  logic [63:0] mpe_pipe [LAT];
  always @(posedge clk) begin
    mpe_pipe[0] <= mpe_setup ? 64'd0 : mpe_f(mpe_data_in1, mpe_data_in2);
    for (int k = 1; k < LAT; k++) mpe_pipe[k] <= mpe_pipe[k-1];
  end
  assign mpe_child_gene = mpe_pipe[LAT-1];

  // Job model: each accepted start at cycle t yields a fixed output timeline.
  typedef struct { int t; int n; logic [63:0] cw; logic [7:0] id; int kill; } job_t;
  job_t jobs[$];
  int   free_at = 0;

  function automatic int done_cycle(input int t, input int n);
    return (n == 0) ? t + 3 : t + 5 + LAT + n;
  endfunction

  task automatic check(input string nm, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
    end
  endtask

  logic        e_busy, e_done, e_rd, e_set, e_we;
  logic [AW-1:0] e_ra, e_wa;
  logic [63:0] e_d1, e_d2, e_wd;
  logic [31:0] e_rand;
  int          jt, jn, ji;
  int          wr_seen = 0, done_seen = 0;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst_q) e_rand = SEED;
      e_busy = 0; e_done = 0; e_rd = 0; e_ra = '0; e_set = 0; e_d1 = '0; e_d2 = '0;
      e_we = 0; e_wa = '0; e_wd = '0;
      foreach (jobs[j]) begin
        if (cyc <= jobs[j].kill) begin
          jt = jobs[j].t; jn = jobs[j].n;
          if (cyc >= jt + 1 && cyc <= done_cycle(jt, jn) - 1) e_busy = 1;
          if (cyc == done_cycle(jt, jn)) e_done = 1;
          if (cyc == jt + 2) begin
            e_set = 1; e_d1 = jobs[j].cw; e_d2 = {56'b0, jobs[j].id};
          end
          ji = cyc - jt - 2;
          if (ji >= 0 && ji < jn) begin e_rd = 1; e_ra = AW'(ji); end
          ji = cyc - jt - 4;
          if (ji >= 0 && ji < jn) begin e_d1 = p1(AW'(ji)); e_d2 = p2(AW'(ji)); end
          ji = cyc - jt - 5 - LAT;
          if (ji >= 0 && ji < jn) begin
            e_we = 1; e_wa = AW'(ji); e_wd = mpe_f(p1(AW'(ji)), p2(AW'(ji)));
          end
        end
      end
      check("ctrl",   {busy, done}, {e_busy, e_done});
      check("rd",     {par_rd_en, par_rd_addr}, {e_rd, e_ra});
      check("mpe_in", {mpe_setup, mpe_data_in1, mpe_data_in2}, {e_set, e_d1, e_d2});
      check("random", mpe_random, {32'b0, e_rand});
      check("child",  {child_wr_en, child_wr_addr, child_wr_data}, {e_we, e_wa, e_wd});
      if (child_wr_en === 1'b1) wr_seen++;
      if (done === 1'b1) done_seen++;
      if (e_busy) e_rand = lstep(e_rand);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic start_job(input logic [63:0] cw, input logic [7:0] id, input int n, output int t);
    job_t j;
    t = cyc;
    cfg_word = cw; cfg_genome_id = id; num_genes = CW'(n); start = 1'b1;
    if (t >= free_at) begin
      j.t = t; j.n = n; j.cw = cw; j.id = id; j.kill = 32'h7fff_ffff;
      jobs.push_back(j);
      free_at = done_cycle(t, n) + 1;
    end
    tick();
    start = 1'b0;
  endtask

  int t1, tx, w0, d0;

  initial begin
    rst = 1'b1; start = 1'b0; cfg_word = '0; cfg_genome_id = '0; num_genes = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 4-pair job with literal pins on LFSR, first write and done timing
    w0 = wr_seen; d0 = done_seen;
    start_job(64'h1020_4040_4040_4040, 8'h07, 4, t1);
    wait_until(t1 + 2);
    check("pin_setup", {mpe_setup, par_rd_en, par_rd_addr}, {1'b1, 1'b1, 10'd0});
    wait_until(t1 + 5);
    check("pin_lfsr4", mpe_random, 64'h0000_0000_8AEE_1245);
    wait_until(t1 + 8);
    check("pin_wr0", {child_wr_en, child_wr_addr, child_wr_data}, {1'b1, 10'd0, 64'hD1CF_0000_0000_0006});
    wait_until(t1 + 12);
    check("pin_done", {done, busy}, {1'b1, 1'b0});
    wait_until(free_at + 1);
    check("wr_cnt4", 160'(wr_seen - w0), 160'd4);

    // empty job
    start_job(64'hDEAD_BEEF_0000_0001, 8'h3C, 0, t1);
    wait_until(t1 + 3);
    check("pin_done0", {done, 160'(wr_seen - w0)}, {1'b1, 160'd4});
    wait_until(free_at + 1);

    // start re-pulse during STREAM is ignored
    w0 = wr_seen; d0 = done_seen;
    start_job(64'h0123_4567_89AB_CDEF, 8'h11, 4, t1);
    wait_until(t1 + 3);
    start_job(64'hFFFF_0000_FFFF_0000, 8'h22, 9, tx);
    wait_until(free_at + 2);
    check("repulse_wr", 160'(wr_seen - w0), 160'd4);
    check("repulse_done", 160'(done_seen - d0), 160'd1);

    // reset two cycles into STREAM, then a clean job
    w0 = wr_seen; d0 = done_seen;
    start_job(64'h5555_AAAA_5555_AAAA, 8'h44, 4, t1);
    wait_until(t1 + 3);
    rst = 1'b1;
    jobs[jobs.size()-1].kill = cyc;
    free_at = cyc + 1;
    tick();
    rst = 1'b0;
    check("rst_out", {busy, done, par_rd_en, par_rd_addr, mpe_setup, child_wr_en, child_wr_addr}, 160'd0);
    check("rst_rand", mpe_random, {32'b0, SEED});
    start_job(64'h0F0F_0F0F_F0F0_F0F0, 8'h55, 4, t1);
    wait_until(free_at + 1);
    check("rst_wr", 160'(wr_seen - w0), 160'd4);
    check("rst_done", 160'(done_seen - d0), 160'd1);

    // full address space
    w0 = wr_seen;
    start_job(64'h1357_9BDF_2468_ACE0, 8'h66, 1024, t1);
    wait_until(t1 + 2 + 1023);
    check("pin_addr_last", {par_rd_en, par_rd_addr}, {1'b1, 10'd1023});
    wait_until(free_at + 1);
    check("wr_cnt1024", 160'(wr_seen - w0), 160'd1024);

    // back-to-back jobs
    start_job(64'hAAAA_0000_0000_0001, 8'h77, 3, t1);
    wait_until(done_cycle(t1, 3) + 1);
    w0 = wr_seen;
    start_job(64'hBBBB_0000_0000_0002, 8'h88, 2, tx);
    wait_until(tx + 2);
    check("b2b_setup", {mpe_setup, mpe_data_in1}, {1'b1, 64'hBBBB_0000_0000_0002});
    wait_until(tx + 5 + LAT);
    check("b2b_wr0", {child_wr_en, child_wr_addr}, {1'b1, 10'd0});
    wait_until(free_at + 2);
    check("b2b_wr", 160'(wr_seen - w0), 160'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mpe_feeder.md
Name: mpe_feeder

Overview:
- Sequencer on the driving side of the mPE crossover/mutation engine. Per job it issues the one-cycle setup word, streams parent gene pairs from two parent gene buffers, and supplies the random pack from an internal LFSR.
- It tracks the mPE's fixed pipeline latency with a tagged valid pipe, then writes each child gene back to a child gene buffer.
- Sits between the population buffers and one mPE instance.

Parameters:
- WORD_SZ, 64, width of mPE data and gene words
- ADDR_W, 10, gene buffer address width
- CNT_W, 16, width of gene-pair count
- MPE_LAT, 3, cycles from mpe_data_in1/2 valid (setup low) to the matching mpe_child_gene valid
- LFSR_SEED, 32'hACE1_2468, non-zero LFSR reset value

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle job start; sampled only in IDLE
- cfg_word  in  WORD_SZ  packed fitnesses and mutation probabilities; becomes the setup data_in1
- cfg_genome_id  in  8  child genome id; becomes setup data_in2[7:0]
- num_genes  in  CNT_W  gene pairs in this job
- par_rd_en  out  1  read strobe to both parent buffers
- par_rd_addr  out  ADDR_W  shared read address
- par1_rd_data  in  WORD_SZ  parent-1 gene, valid the cycle after par_rd_en
- par2_rd_data  in  WORD_SZ  parent-2 gene, same timing
- mpe_setup  out  1  mPE setup strobe
- mpe_data_in1  out  WORD_SZ  mPE data_in1
- mpe_data_in2  out  WORD_SZ  mPE data_in2
- mpe_random  out  WORD_SZ  mPE random_num_pack; [63:32] are zero
- mpe_child_gene  in  WORD_SZ  mPE child_gene
- child_wr_en  out  1  child buffer write strobe
- child_wr_addr  out  ADDR_W  child write address
- child_wr_data  out  WORD_SZ  child gene
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse

Behaviour:
- All outputs are registered.
- Reset values:
  - all outputs 0, except mpe_random = {32'b0, LFSR_SEED}
  - FSM in IDLE; valid pipe cleared
- Reset mid-job aborts immediately: no further writes, no done pulse.
- FSM states: IDLE, SETUP, STREAM, DRAIN, FIN.
- IDLE:
  - start=1 latches cfg_word, cfg_genome_id and num_genes; goes to SETUP and sets busy=1.
  - start in any other state is ignored.
- SETUP (1 cycle):
  - Loads mpe_setup=1, mpe_data_in1=cfg_word, mpe_data_in2={56'b0, cfg_genome_id}; these are visible the next cycle for exactly one cycle.
  - Next state is STREAM if num_genes>0, else DRAIN.
- STREAM:
  - par_rd_en=1 for exactly num_genes consecutive cycles, addresses 0..num_genes-1. The address wraps modulo 2^ADDR_W.
  - Then DRAIN.
- Data path: when a read is issued in cycle c, par1/par2 data are registered onto mpe_data_in1/2 with mpe_setup=0 in cycle c+2.
- Whenever no pair is being presented, mpe_setup=0 and mpe_data_in1/2 are 0. Any mPE output from these slots is discarded.
- Valid pipe:
  - Depth MPE_LAT+2. A bit plus index is pushed for each read issued.
  - At tag exit (cycle c+2+MPE_LAT), mpe_child_gene is registered so that child_wr_en=1, child_wr_addr=index, child_wr_data=gene in cycle c+3+MPE_LAT (c+6 at default).
- Writes are back-to-back, in order, with no gaps and no stalls. The child buffer always accepts.
- DRAIN: stays until the valid pipe is empty and the last write has been issued, then FIN.
- FIN (1 cycle): done=1 and busy drops to 0 in the same cycle, then IDLE.
- A new start in the cycle after done is accepted.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
  - Advances once per cycle while busy=1, holds otherwise.
  - mpe_random reflects the current state.
- Counter widths: the read and write counters are CNT_W bits; num_genes is a full unsigned count.

Decomposition:
- Shared package mpe_pkg: WORD_SZ, ATTR_SZ=8, MPE_LAT, the FSM state enum, and the LFSR polynomial constant.
- One natural sub-module, lfsr32 (enable, seed parameter, 32-bit state output). The valid/index pipe is inlined.

Test Plan:
- num_genes=4, cfg_word=64'h1020_4040_4040_4040, id=8'h07 -> mpe_setup high exactly 1 cycle carrying those words; par_rd_en 4 cycles at addr 0..3; child_wr_en 4 consecutive cycles at addr 0..3, the first 6 cycles after the first par_rd_en; child_wr_data equals the mpe_child_gene from that pair's slot (use a behavioural mPE model); done 1 cycle after the last write.
- num_genes=0 -> one setup cycle, no par_rd_en, no child_wr_en, done within MPE_LAT+4 cycles of start.
- start re-pulsed during STREAM with num_genes=9 -> ignored: write count still 4, one done.
- rst asserted 2 cycles into STREAM -> next cycle all outputs 0, no writes, no done; a fresh start then completes a full 4-pair job normally.
- num_genes=1024 with ADDR_W=10 -> addresses 0..1023 with no skip, 1024 writes; mpe_random changes every busy cycle and [63:32] stays 0.
- Back-to-back jobs (start the cycle after done) -> second job's setup word appears and its writes restart at addr 0.
